// File: rtl/sayeh_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sayeh_mem_arbiter
//
// Two-port round-robin arbiter and access sequencer for the single-port
// 1K x 16 Sayeh main memory. Port A (CPU datapath) and port B (DMA/loader)
// each hold req until their ack. The granted access is sequenced through
// IDLE -> ISSUE -> WAIT -> RECOVER. The memory answers with rdy, which it
// changes on the falling clock edge. Every output is a flop.
//
// Ports
//   clk, ExternalReset       clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request (held until a_ack)
//   a_ack/a_err/a_rdata        port A one-cycle completion, timeout flag,
//                              read data (held until the next A read)
//   b_*                        same for port B
//   mem_addr/mem_din           address / write data to the memory
//   mem_nd/mem_we              read / write strobes to the memory
//   mem_dout/mem_rdy           read data / ready from the memory
// -----------------------------------------------------------------------------
module sayeh_mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              ExternalReset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_nd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_rdy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                gnt_b_q, gnt_b_d;       // 1 = current access belongs to B
  logic                prefer_b_q, prefer_b_d; // 1 = B wins the next tie
  logic                we_l_q, we_l_d;
  logic [ADDR_W-1:0]   addr_l_q, addr_l_d;
  logic [DATA_W-1:0]   wdata_l_q, wdata_l_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                mem_nd_q, mem_nd_d;
  logic                mem_we_q, mem_we_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic                a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic                grant_valid_s;
  logic                grant_b_s;
  logic [7:0]          cnt_inc_s;
  logic                cnt_expire_s;

  // Round-robin choice among the requests present this cycle.
  always_comb begin
    grant_valid_s = a_req | b_req;
    if (a_req && b_req) begin
      grant_b_s = prefer_b_q;
    end else if (b_req) begin
      grant_b_s = 1'b1;
    end else begin
      grant_b_s = 1'b0;
    end
  end

  // One counter bounds both WAIT (no rdy) and RECOVER (rdy stuck high).
  always_comb begin
    cnt_inc_s    = cnt_q + 8'd1;
    cnt_expire_s = (cnt_inc_s == TIMEOUT_C);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge ExternalReset) begin
    if (ExternalReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rdy || cnt_expire_s) begin
          state_d = ST_RECOVER;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RECOVER: begin
        // rdy stays high until the memory sees nd=0 on a falling edge.
        if (!mem_rdy || cnt_expire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: next values for the request latch and all output flops.
  always_comb begin
    gnt_b_d    = gnt_b_q;
    prefer_b_d = prefer_b_q;
    we_l_d     = we_l_q;
    addr_l_d   = addr_l_q;
    wdata_l_d  = wdata_l_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_nd_d   = mem_nd_q;
    mem_we_d   = mem_we_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        mem_nd_d = 1'b0;
        mem_we_d = 1'b0;
        if (grant_valid_s) begin
          gnt_b_d    = grant_b_s;
          prefer_b_d = ~grant_b_s;
          if (grant_b_s) begin
            we_l_d    = b_we;
            addr_l_d  = b_addr;
            wdata_l_d = b_wdata;
          end else begin
            we_l_d    = a_we;
            addr_l_d  = a_addr;
            wdata_l_d = a_wdata;
          end
        end else begin
          gnt_b_d = gnt_b_q;
        end
      end
      ST_ISSUE: begin
        mem_addr_d = addr_l_q;
        mem_din_d  = wdata_l_q;
        mem_nd_d   = ~we_l_q;
        mem_we_d   = we_l_q;
        cnt_d      = 8'd0;
      end
      ST_WAIT: begin
        if (mem_rdy) begin
          mem_nd_d = 1'b0;
          mem_we_d = 1'b0;
          cnt_d    = 8'd0;
          if (gnt_b_q) begin
            b_ack_d = 1'b1;
            if (!we_l_q) begin
              b_rdata_d = mem_dout;
            end else begin
              b_rdata_d = b_rdata_q;
            end
          end else begin
            a_ack_d = 1'b1;
            if (!we_l_q) begin
              a_rdata_d = mem_dout;
            end else begin
              a_rdata_d = a_rdata_q;
            end
          end
        end else if (cnt_expire_s) begin
          // Abort: report the error, read data is left untouched.
          mem_nd_d = 1'b0;
          mem_we_d = 1'b0;
          cnt_d    = 8'd0;
          if (gnt_b_q) begin
            b_ack_d = 1'b1;
            b_err_d = 1'b1;
          end else begin
            a_ack_d = 1'b1;
            a_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_RECOVER: begin
        mem_nd_d = 1'b0;
        mem_we_d = 1'b0;
        if (mem_rdy && !cnt_expire_s) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = 8'd0;
        end
      end
      default: begin
        mem_nd_d = 1'b0;
        mem_we_d = 1'b0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  // Request latch, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge ExternalReset) begin
    if (ExternalReset) begin
      gnt_b_q    <= 1'b0;
      prefer_b_q <= 1'b0;
      we_l_q     <= 1'b0;
      addr_l_q   <= {ADDR_W{1'b0}};
      wdata_l_q  <= {DATA_W{1'b0}};
      cnt_q      <= 8'd0;
      mem_addr_q <= {ADDR_W{1'b0}};
      mem_din_q  <= {DATA_W{1'b0}};
      mem_nd_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= {DATA_W{1'b0}};
      b_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      gnt_b_q    <= gnt_b_d;
      prefer_b_q <= prefer_b_d;
      we_l_q     <= we_l_d;
      addr_l_q   <= addr_l_d;
      wdata_l_q  <= wdata_l_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_nd_q   <= mem_nd_d;
      mem_we_q   <= mem_we_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_ack    = a_ack_q;
  assign a_err    = a_err_q;
  assign a_rdata  = a_rdata_q;
  assign b_ack    = b_ack_q;
  assign b_err    = b_err_q;
  assign b_rdata  = b_rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_nd   = mem_nd_q;
  assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_sayeh_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sayeh_mem_arbiter
//
// Bench for sayeh_mem_arbiter: a negedge memory model with adjustable
// latency (or no response at all), directed scenarios, and a randomized
// two-requester phase scored against a transaction-level round-robin model
// and a shadow copy of the memory contents.
// -----------------------------------------------------------------------------
module tb_sayeh_mem_arbiter;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              ExternalReset;
  logic              a_req, a_we, a_ack, a_err;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_we, b_ack, b_err;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              mem_nd, mem_we, mem_rdy;

  int checks = 0;
  int errors = 0;

  // memory model controls
  bit                mem_dead;
  int                mem_lat;
  bit                mem_init_done;
  int                lat_cnt;
  logic [DATA_W-1:0] mem_arr [1024];

  // scoreboard state
  logic [DATA_W-1:0] ref_mem [1024];
  bit                pa, pb;
  bit                a_ack_prev, b_ack_prev;

  sayeh_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .ExternalReset(ExternalReset),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_ack        (a_ack),
    .a_err        (a_err),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_ack        (b_ack),
    .b_err        (b_err),
    .b_rdata      (b_rdata),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_nd       (mem_nd),
    .mem_we       (mem_we),
    .mem_dout     (mem_dout),
    .mem_rdy      (mem_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 5) return 16'hBEEF;
    return 16'(i * 40503 + 7);
  endfunction

  // Memory model: acts on the falling edge, rdy sticky until strobes drop.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] = init_word(i);
      mem_init_done = 1'b1;
      mem_rdy       = 1'b0;
      mem_dout      = 16'h0000;
      lat_cnt       = 0;
    end else if (mem_nd || mem_we) begin
      if (!mem_dead && !mem_rdy) begin
        if (lat_cnt >= mem_lat) begin
          if (mem_we) mem_arr[mem_addr] = mem_din;
          else        mem_dout = mem_arr[mem_addr];
          mem_rdy = 1'b1;
        end else begin
          lat_cnt++;
        end
      end
    end else begin
      mem_rdy  = 1'b0;
      lat_cnt  = 0;
      mem_dout = 16'h0000;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the always-true properties.
  task automatic step();
    @(posedge clk);
    #1;
    check("strobe_overlap", 32'(mem_nd & mem_we), 32'd0);
    check("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
    check("a_ack_pulse", 32'(a_ack & a_ack_prev), 32'd0);
    check("b_ack_pulse", 32'(b_ack & b_ack_prev), 32'd0);
    a_ack_prev = a_ack;
    b_ack_prev = b_ack;
  endtask

  task automatic wait_ack(input int budget, output int cycles, output bit got_a,
                          output bit got_b, output bit nd_seen);
    cycles  = 0;
    got_a   = 1'b0;
    got_b   = 1'b0;
    nd_seen = 1'b0;
    while (!got_a && !got_b && cycles < budget) begin
      step();
      cycles++;
      if (mem_nd) nd_seen = 1'b1;
      got_a = a_ack;
      got_b = b_ack;
    end
    check("ack_arrived", 32'(got_a | got_b), 32'd1);
  endtask

  task automatic do_reset();
    ExternalReset = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ExternalReset = 1'b0;
    a_ack_prev = 1'b0;
    b_ack_prev = 1'b0;
  endtask

  task automatic rand_req_a();
    pa      = 1'b1;
    a_req   = 1'b1;
    a_we    = 1'($urandom_range(0, 1));
    a_addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
    a_wdata = 16'($urandom);
  endtask

  task automatic rand_req_b();
    pb      = 1'b1;
    b_req   = 1'b1;
    b_we    = 1'($urandom_range(0, 1));
    b_addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
    b_wdata = 16'($urandom);
  endtask

  initial begin
    int                cyc, nd_cnt, extra_ack, idle_cnt;
    bit                ga, gb, nds, last_b;
    logic [1:0]        sel;
    logic [DATA_W-1:0] exp_ra, exp_rb;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    ExternalReset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 10'd0; a_wdata = 16'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 10'd0; b_wdata = 16'd0;
    mem_dead = 1'b0;
    mem_lat  = 0;
    a_ack_prev = 1'b0;
    b_ack_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_nd", 32'(mem_nd), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_b_rdata", 32'(b_rdata), 32'd0);
    ExternalReset = 1'b0;

    // 1: single A read of the preloaded word
    a_we = 1'b0; a_addr = 10'h005; a_req = 1'b1;
    wait_ack(40, cyc, ga, gb, nds);
    a_req = 1'b0;
    check("t1_latency", 32'(cyc), 32'd3);
    check("t1_port_a", 32'(ga), 32'd1);
    check("t1_no_b", 32'(gb), 32'd0);
    check("t1_nd_seen", 32'(nds), 32'd1);
    check("t1_rdata", 32'(a_rdata), 32'h0000BEEF);
    check("t1_err", 32'(a_err), 32'd0);
    repeat (2) step();

    // 2: B write to the top address, then A reads it back
    b_we = 1'b1; b_addr = 10'h3FF; b_wdata = 16'h1234; b_req = 1'b1;
    wait_ack(40, cyc, ga, gb, nds);
    b_req = 1'b0;
    ref_mem[10'h3FF] = 16'h1234;
    check("t2_latency", 32'(cyc), 32'd3);
    check("t2_port_b", 32'(gb), 32'd1);
    check("t2_err", 32'(b_err), 32'd0);
    check("t2_rdata_kept", 32'(b_rdata), 32'd0);
    repeat (2) step();
    a_we = 1'b0; a_addr = 10'h3FF; a_req = 1'b1;
    wait_ack(40, cyc, ga, gb, nds);
    a_req = 1'b0;
    check("t2_readback", 32'(a_rdata), 32'h00001234);
    repeat (2) step();

    // 3: contention from reset -> A, B, A, B
    do_reset();
    a_we = 1'b0; a_addr = 10'h010; a_req = 1'b1;
    b_we = 1'b0; b_addr = 10'h020; b_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(40, cyc, ga, gb, nds);
      check("t3_order", 32'(gb), 32'(k % 2));
      check("t3_strobe_gap", 32'({mem_nd, mem_we}), 32'd0);
      if (gb) check("t3_b_rdata", 32'(b_rdata), 32'(ref_mem[10'h020]));
      else    check("t3_a_rdata", 32'(a_rdata), 32'(ref_mem[10'h010]));
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) step();

    // 4: memory never answers -> abort 15 edges after ISSUE
    mem_dead = 1'b1;
    a_we = 1'b0; a_addr = 10'h011; a_req = 1'b1;
    wait_ack(40, cyc, ga, gb, nds);
    a_req = 1'b0;
    check("t4_latency", 32'(cyc), 32'(TIMEOUT + 2));
    check("t4_port_a", 32'(ga), 32'd1);
    check("t4_err", 32'(a_err), 32'd1);
    check("t4_rdata_kept", 32'(a_rdata), 32'(ref_mem[10'h010]));
    mem_dead = 1'b0;
    repeat (3) step();
    b_we = 1'b0; b_addr = 10'h022; b_req = 1'b1;
    wait_ack(40, cyc, ga, gb, nds);
    b_req = 1'b0;
    check("t4_next_latency", 32'(cyc), 32'd3);
    check("t4_next_err", 32'(b_err), 32'd0);
    check("t4_next_rdata", 32'(b_rdata), 32'(ref_mem[10'h022]));
    repeat (2) step();

    // 5: reset while a B read sits in WAIT
    mem_dead = 1'b1;
    b_we = 1'b0; b_addr = 10'h030; b_req = 1'b1;
    repeat (4) step();
    check("t5_in_wait", 32'(mem_nd), 32'd1);
    #2;
    ExternalReset = 1'b1;
    #1;
    check("t5_nd_drop", 32'(mem_nd), 32'd0);
    check("t5_no_ack", 32'(b_ack), 32'd0);
    b_req = 1'b0;
    mem_dead = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("t5_no_ack_rst", 32'(b_ack), 32'd0);
    end
    ExternalReset = 1'b0;
    a_we = 1'b0; a_addr = 10'h031; a_req = 1'b1;
    b_we = 1'b0; b_addr = 10'h032; b_req = 1'b1;
    wait_ack(40, cyc, ga, gb, nds);
    a_req = 1'b0;
    check("t5_first_a", 32'(ga), 32'd1);
    check("t5_first_lat", 32'(cyc), 32'd3);
    wait_ack(40, cyc, ga, gb, nds);
    b_req = 1'b0;
    check("t5_then_b", 32'(gb), 32'd1);
    check("t5_b_rdata", 32'(b_rdata), 32'(ref_mem[10'h032]));
    repeat (2) step();

    // 6: one-cycle req pulse still completes exactly once
    a_we = 1'b0; a_addr = 10'h040; a_req = 1'b1;
    step();
    a_req = 1'b0;
    wait_ack(40, cyc, ga, gb, nds);
    check("t6_latency", 32'(cyc), 32'd2);
    check("t6_port_a", 32'(ga), 32'd1);
    check("t6_rdata", 32'(a_rdata), 32'(ref_mem[10'h040]));
    nd_cnt = 0;
    extra_ack = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (mem_nd || mem_we) nd_cnt++;
      if (a_ack) extra_ack++;
    end
    check("t6_no_reissue", 32'(nd_cnt), 32'd0);
    check("t6_single_ack", 32'(extra_ack), 32'd0);

    // Randomized phase against the round-robin / shadow-memory model
    do_reset();
    pa = 1'b0; pb = 1'b0;
    last_b   = 1'b1;
    exp_ra   = 16'h0000;
    exp_rb   = 16'h0000;
    idle_cnt = 0;
    for (int c = 0; c < 2500; c++) begin
      if (!pa && !pb) begin
        if (idle_cnt == 0) begin
          sel = 2'($urandom_range(1, 3));
          if (sel[0]) rand_req_a();
          if (sel[1]) rand_req_b();
        end else begin
          idle_cnt--;
        end
      end
      step();
      if (a_ack || b_ack) begin
        gb = b_ack;
        check("rnd_pending", 32'(gb ? pb : pa), 32'd1);
        check("rnd_rr_port", 32'(gb), 32'((pa && pb) ? !last_b : pb));
        check("rnd_strobes_low", 32'({mem_nd, mem_we}), 32'd0);
        last_b  = gb;
        mem_lat = $urandom_range(0, 3);
        if (!gb) begin
          if (!a_we) exp_ra = ref_mem[a_addr];
          else       ref_mem[a_addr] = a_wdata;
          check("rnd_a_rdata", 32'(a_rdata), 32'(exp_ra));
          check("rnd_a_err", 32'(a_err), 32'd0);
          if ($urandom_range(0, 3) != 0) rand_req_a();
          else begin pa = 1'b0; a_req = 1'b0; end
        end else begin
          if (!b_we) exp_rb = ref_mem[b_addr];
          else       ref_mem[b_addr] = b_wdata;
          check("rnd_b_rdata", 32'(b_rdata), 32'(exp_rb));
          check("rnd_b_err", 32'(b_err), 32'd0);
          if ($urandom_range(0, 3) != 0) rand_req_b();
          else begin pb = 1'b0; b_req = 1'b0; end
        end
        if (!pa && !pb) idle_cnt = $urandom_range(0, 4);
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
